dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Initiator-side memory bridge between the pipeline's single-cycle data-memory port (memread/memwrite, addr, wd, rd) and a slower handshaked data memory (req/ack). It turns each M-stage load or store into one req/ack transaction. While the transaction is outstanding it holds the pipeline stalled. It also returns the load data and flags misaligned or timed-out accesses. The block sits between the M-stage datapath and the external data RAM; its `stall` output ORs into the hazard unit's stall logic.

## Interface
- `TIMEOUT`, 255: maximum BUSY cycles to wait for `mem_ack` before aborting.
- `ERRDATA`, 32'hDEADBEEF: value returned on `rd` for an aborted load.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high. All state clears on the clock edge where `reset` is 1.
- `memread` input 1: M-stage load request.
- `memwrite` input 1: M-stage store request. `memread` and `memwrite` are never both high; if they are, the store wins.
- `addr` input 32: byte address.
- `wd` input 32: store data.
- `rd` output 32: load data register.
- `stall` output 1: freezes the pipeline (combinational).
- `err` output 1: sticky error flag.
- `mem_req` output 1: transaction request (registered).
- `mem_we` output 1: 1 = write (registered).
- `mem_addr` output 30: word address, `addr[31:2]` (registered).
- `mem_wdata` output 32: store data (registered).
- `mem_ack` input 1: one-cycle completion pulse from memory.
- `mem_rdata` input 32: read data, valid when `mem_ack` is 1.

## Operation
- States:
  - IDLE: no transaction.
  - BUSY: request outstanding.
  - DONE: one-cycle release.
- Reset values:
  - state is IDLE.
  - `rd`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `err` are 0.
  - The timeout counter is 0.
- IDLE with `(memread|memwrite)` and `addr[1:0]==0`:
  - `stall` is 1 combinationally.
  - On the clock edge, latch `mem_we=memwrite`, `mem_addr=addr[31:2]`, `mem_wdata=wd`, set `mem_req=1`, clear the counter, and go to BUSY.
- IDLE with a request and `addr[1:0]!=0` (misaligned):
  - No transaction and no stall.
  - `err` is set.
  - A load writes `ERRDATA` to `rd`; a store is dropped.
- IDLE with no request: outputs hold and `stall` is 0.
- BUSY:
  - `stall` is 1.
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable.
  - The counter increments each cycle.
- BUSY with `mem_ack`:
  - `mem_req` drops to 0.
  - If `mem_we` is 0, `rd` captures `mem_rdata`.
  - Next state is DONE.
- BUSY with no ack when the counter reaches `TIMEOUT-1`:
  - Abort: `mem_req` goes to 0 and `err` is set.
  - A load writes `ERRDATA` to `rd`.
  - Next state is DONE.
- DONE:
  - `stall` is 0, so the pipeline advances at the end of this cycle. `rd` is valid for the M→W register during this cycle.
  - Next state is IDLE unconditionally. This guarantees the same instruction is never issued twice.
- `mem_ack` outside BUSY is ignored. This includes a late ack after a timeout.
- `err` clears only on `reset`.

## Timing
- Minimum transaction, ack in the first BUSY cycle:
  - Cycle 0: request seen in IDLE, `stall`=1.
  - Cycle 1: BUSY, `mem_req`=1, ack arrives.
  - Cycle 2: DONE, `stall`=0.
  - Total 3 cycles, 2 of them stalled.
- Ack arriving in BUSY cycle k (k≥1) gives k+1 stalled cycles.
- A timeout gives exactly `TIMEOUT`+1 stalled cycles.
- Back-to-back memory instructions: the next instruction's request is seen in the IDLE cycle right after DONE. Minimum spacing is 3 cycles per access.
- `reset` asserted in BUSY:
  - `mem_req` drops on that edge and the state returns to IDLE.
  - `stall` is 0 from the following cycle.
  - The memory must tolerate a dropped request.
- `stall` depends combinationally only on state, `memread`, `memwrite` and `addr[1:0]`. There is no combinational path from `mem_ack` to `stall`.

## Structure
- Package `dmem_bridge_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, BUSY, DONE} bridge_state_t`.
  - The default `ERRDATA` constant.
- One sub-module, `wdog_cnt #(MAX)`: a synchronous-reset counter with `clr`/`en` inputs and a `hit` output when the count equals MAX-1, width `$clog2(MAX)`.
- The existing async-reset flops are not reused, because reset here is synchronous.

## Test plan
- Load, `addr`=32'h10, ack one cycle after `mem_req` with `mem_rdata`=32'hCAFEF00D: `mem_addr`=30'h4, `mem_we`=0, `stall` high 2 cycles, `rd`=32'hCAFEF00D in DONE, `err`=0.
- Store, `addr`=32'h20, `wd`=32'h12345678, ack after 5 cycles: `mem_we`=1, `mem_addr`=30'h8, `mem_wdata` stable throughout BUSY, `stall` high 6 cycles, `rd` unchanged.
- Load with no ack, `TIMEOUT`=8: abort after 8 BUSY cycles, `err`=1, `rd`=32'hDEADBEEF. A late ack 2 cycles later is ignored and `rd` is unchanged.
- Misaligned load, `addr`=32'h13: `mem_req` never rises, `stall`=0, `err`=1 next cycle, `rd`=32'hDEADBEEF.
- `reset` pulsed in the 3rd BUSY cycle: next cycle `mem_req`=0, `err`=0, state IDLE, `stall`=0 with no request present.
- Two back-to-back loads (addr 0x0 then 0x4, immediate acks): exactly two `mem_req` pulses, 3 cycles apart, with correct `rd` for each.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge.
// Holds the bridge FSM state encoding and the default error data word.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } bridge_state_t;

    localparam logic [31:0] ERRDATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_bridge_wdog_cnt.sv
// Watchdog counter: counts enabled cycles, flags when count equals MAX-1.
// Ports: clk, reset (sync, active-high), clr, en -> hit.
module wdog_cnt #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int W = $clog2(MAX);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign hit = (r_cnt == W'(MAX - 1));

endmodule

// File: rtl/dmem_bridge.sv
// Bridge from the single-cycle M-stage memory port to a req/ack data RAM.
// Ports: memread/memwrite/addr/wd in, rd/stall/err out; mem_* handshake.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] ERRDATA = ERRDATA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        stall,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    bridge_state_t r_state;
    logic [31:0]   r_rd;
    logic          r_err;
    logic          r_req;
    logic          r_we;
    logic [29:0]   r_addr;
    logic [31:0]   r_wdata;

    logic w_req;
    logic w_aligned;
    logic w_hit;

    assign w_req     = memread | memwrite;
    assign w_aligned = (addr[1:0] == 2'b00);

    // Counter is held clear while idle so each transaction starts at 0.
    wdog_cnt #(
        .MAX(TIMEOUT)
    ) u_wdog (
        .clk  (clk),
        .reset(reset),
        .clr  (r_state == IDLE),
        .en   (r_state == BUSY),
        .hit  (w_hit)
    );

    // No mem_ack term here: stall must not depend on the memory combinationally.
    assign stall = (r_state == BUSY) ||
                   ((r_state == IDLE) && w_req && w_aligned);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_rd    <= '0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req && w_aligned) begin
                        // Store wins if both strobes are high.
                        r_we    <= memwrite;
                        r_addr  <= addr[31:2];
                        r_wdata <= wd;
                        r_req   <= 1'b1;
                        r_state <= BUSY;
                    end else if (w_req) begin
                        r_err <= 1'b1;
                        if (!memwrite) begin
                            r_rd <= ERRDATA;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_rd <= mem_rdata;
                        end
                        r_state <= DONE;
                    end else if (w_hit) begin
                        r_req <= 1'b0;
                        r_err <= 1'b1;
                        if (!r_we) begin
                            r_rd <= ERRDATA;
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rd        = r_rd;
    assign err       = r_err;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge (TIMEOUT=8).
// Ports: drives the M-stage side and plays the memory by hand.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_pulse;
    int pulse_cyc [2];
    logic prev_req = 1'b0;
    int   nst;

    dmem_bridge #(
        .TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memread  (memread),
        .memwrite (memwrite),
        .addr     (addr),
        .wd       (wd),
        .rd       (rd),
        .stall    (stall),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record rising edges of mem_req.
    always @(negedge clk) begin
        if (mem_req && !prev_req) begin
            if (n_pulse < 2) pulse_cyc[n_pulse] = cyc;
            n_pulse = n_pulse + 1;
        end
        prev_req = mem_req;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_run = n_run + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one access; ack in the k-th BUSY cycle (k=0: never).
    // Returns in the DONE cycle with the number of stalled cycles.
    task automatic run_acc(input logic we, input logic [31:0] a,
                           input logic [31:0] d, input int k,
                           input logic [31:0] rdat, output int ns);
        int b;
        ns = 0;
        b = 0;
        memread  = ~we;
        memwrite = we;
        addr     = a;
        wd       = d;
        mem_ack  = 1'b0;
        #1;
        while (stall && ns < 400) begin
            ns = ns + 1;
            if (mem_req) begin
                b = b + 1;
                chk("busy_addr", {2'b0, mem_addr}, {2'b0, a[31:2]});
                chk("busy_we", {31'b0, mem_we}, {31'b0, we});
                chk("busy_wdata", mem_wdata, d);
                mem_ack   = (b == k);
                mem_rdata = rdat;
            end
            step();
            mem_ack = 1'b0;
            #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        memread   = 1'b0;
        memwrite  = 1'b0;
        addr      = '0;
        wd        = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        n_pulse   = 0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_rd", rd, 32'h0);
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_addr", {2'b0, mem_addr}, 32'h0);

        // Load, ack in first BUSY cycle.
        run_acc(1'b0, 32'h10, 32'h0, 1, 32'hCAFEF00D, nst);
        chk("ld_stalls", nst, 2);
        chk("ld_rd", rd, 32'hCAFEF00D);
        chk("ld_err", {31'b0, err}, 32'h0);
        chk("ld_addr", {2'b0, mem_addr}, 32'h4);
        chk("ld_req_done", {31'b0, mem_req}, 32'h0);
        memread = 1'b0;
        step();

        // Store, ack after 5 BUSY cycles.
        run_acc(1'b1, 32'h20, 32'h12345678, 5, 32'h55555555, nst);
        chk("st_stalls", nst, 6);
        chk("st_we", {31'b0, mem_we}, 32'h1);
        chk("st_addr", {2'b0, mem_addr}, 32'h8);
        chk("st_rd", rd, 32'hCAFEF00D);
        memwrite = 1'b0;
        step();

        // Back-to-back loads.
        n_pulse = 0;
        run_acc(1'b0, 32'h0, 32'h0, 1, 32'h11111111, nst);
        chk("b2b_rd0", rd, 32'h11111111);
        step();
        run_acc(1'b0, 32'h4, 32'h0, 1, 32'h22222222, nst);
        chk("b2b_rd1", rd, 32'h22222222);
        memread = 1'b0;
        step();
        step();
        chk("b2b_pulses", n_pulse, 2);
        chk("b2b_space", pulse_cyc[1] - pulse_cyc[0], 3);

        // Timeout: no ack.
        run_acc(1'b0, 32'h40, 32'h0, 0, 32'h0, nst);
        chk("to_stalls", nst, 9);
        chk("to_err", {31'b0, err}, 32'h1);
        chk("to_rd", rd, 32'hDEADBEEF);
        chk("to_req", {31'b0, mem_req}, 32'h0);
        memread = 1'b0;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h99999999;
        step();
        mem_ack = 1'b0;
        #1;
        chk("late_rd", rd, 32'hDEADBEEF);
        chk("late_stall", {31'b0, stall}, 32'h0);
        chk("late_req", {31'b0, mem_req}, 32'h0);

        // Misaligned load after reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rst2_err", {31'b0, err}, 32'h0);
        memread = 1'b1;
        addr    = 32'h13;
        #1;
        chk("mis_stall", {31'b0, stall}, 32'h0);
        step();
        memread = 1'b0;
        #1;
        chk("mis_err", {31'b0, err}, 32'h1);
        chk("mis_rd", rd, 32'hDEADBEEF);
        chk("mis_req", {31'b0, mem_req}, 32'h0);

        // Reset in the 3rd BUSY cycle.
        memread = 1'b1;
        addr    = 32'h80;
        step();
        chk("rb_req1", {31'b0, mem_req}, 32'h1);
        step();
        step();
        chk("rb_stall3", {31'b0, stall}, 32'h1);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        memread = 1'b0;
        #1;
        chk("rb_req", {31'b0, mem_req}, 32'h0);
        chk("rb_err", {31'b0, err}, 32'h0);
        chk("rb_stall", {31'b0, stall}, 32'h0);
        step();
        chk("rb_stall2", {31'b0, stall}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
